// File: rtl/fetch_decode.sv
// Fetch/decode stage: issues one instruction read per PC, latches the returned
// opcode/operand with a precomputed result-mux select, and waits for a redirect after branches.
module fetch_decode #(
    parameter logic [3:0] RESET_PC = 4'h0,
    parameter logic [3:0] PC_STEP  = 4'h2
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] mem_addr,
    output logic       mem_rd_en,
    input  logic       mem_rvalid,
    input  logic [3:0] mem_opcode,
    input  logic [3:0] mem_data,
    output logic       dec_valid,
    input  logic       dec_ready,
    output logic [3:0] dec_opcode,
    output logic [3:0] dec_data,
    output logic [2:0] dec_sel,
    output logic       dec_branch,
    output logic [3:0] dec_pc,
    input  logic       redirect_valid,
    input  logic [3:0] redirect_pc
);

    typedef enum logic [1:0] {StFetch, StWait, StOut, StRedir} state_e;

    state_e     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] opcode_q, data_q, dpc_q;
    logic [2:0] sel_q;
    logic       latch_en;

    // Select bits are {X,Y,Z}; computed from the incoming opcode so they register alongside it.
    function automatic logic [2:0] decode_sel(input logic [3:0] op);
        logic x, y, z;
        x = (op[3] | op[2]) & ~op[1] & ~op[0];
        y = (op[3] & op[2] & ~op[1] & ~op[0]) | (~op[3] & ~op[2] & op[1]);
        z = (~op[3] & ~op[2] & op[0]) | (op[3] & ~op[2] & ~op[1] & ~op[0]);
        return {x, y, z};
    endfunction

    assign latch_en = (state_q == StWait) && mem_rvalid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StFetch: state_d = StWait;
            StWait: begin
                if (mem_rvalid) state_d = StOut;
            end
            StOut: begin
                if (dec_ready) begin
                    if (opcode_q[3]) begin
                        state_d = StRedir;
                    end else begin
                        state_d = StFetch;
                        pc_d    = pc_q + PC_STEP;
                    end
                end
            end
            StRedir: begin
                if (redirect_valid) begin
                    state_d = StFetch;
                    pc_d    = redirect_pc;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StFetch;
            pc_q     <= RESET_PC;
            opcode_q <= 4'h0;
            data_q   <= 4'h0;
            sel_q    <= 3'b000;
            dpc_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (latch_en) begin
                opcode_q <= mem_opcode;
                data_q   <= mem_data;
                sel_q    <= decode_sel(mem_opcode);
                dpc_q    <= pc_q;
            end
        end
    end

    // The read request is suppressed while reset is held even though the state already reads FETCH.
    assign mem_rd_en  = (state_q == StFetch) && !reset;
    assign mem_addr   = pc_q;
    assign dec_valid  = (state_q == StOut);
    assign dec_opcode = opcode_q;
    assign dec_data   = data_q;
    assign dec_sel    = sel_q;
    assign dec_branch = opcode_q[3];
    assign dec_pc     = dpc_q;

endmodule
